// File: rtl/ad9911_pkg.sv
// rtl/ad9911_pkg.sv - shared register map, byte-count lookup and FSM states for the AD9911 writer
package ad9911_pkg;

  localparam logic [4:0] REG_CSR   = 5'h00;
  localparam logic [4:0] REG_FR1   = 5'h01;
  localparam logic [4:0] REG_FR2   = 5'h02;
  localparam logic [4:0] REG_CFR   = 5'h03;
  localparam logic [4:0] REG_CTW0  = 5'h04;
  localparam logic [4:0] REG_CPOW0 = 5'h05;
  localparam logic [4:0] REG_ACR   = 5'h06;
  localparam logic [4:0] REG_LSR   = 5'h07;
  localparam logic [4:0] REG_RDW   = 5'h08;
  localparam logic [4:0] REG_FDW   = 5'h09;
  localparam logic [4:0] REG_CTW1  = 5'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_UPDATE
  } ad9911_state_t;

  // Natural data width of each register in bytes; everything past LSR is 32 bits wide.
  function automatic logic [2:0] ad9911_reg_bytes(input logic [4:0] addr);
    logic [2:0] n;
    case (addr)
      REG_CSR:                      n = 3'd1;
      REG_FR2, REG_CPOW0, REG_LSR:  n = 3'd2;
      REG_FR1, REG_CFR, REG_ACR:    n = 3'd3;
      default:                      n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ad9911_sclk_tick.sv
// rtl/ad9911_sclk_tick.sv - down-counter giving a one-cycle tick every CLK_DIV cycles
module ad9911_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam logic [7:0] RELOAD_VAL = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == 8'd0);

  // Restart the phase on every state change so each state lasts exactly CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (reload || cnt == 8'd0) begin
      cnt <= RELOAD_VAL;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/ad9911_spi_writer.sv
// rtl/ad9911_spi_writer.sv - AD9911 3-wire serial register writer with IO_UPDATE strobe
module ad9911_spi_writer
  import ad9911_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int UPDATE_WIDTH = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        TR,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DATA,
  output logic        OVER,
  output logic        CS_N,
  output logic        SCLK,
  output logic        SDIO,
  output logic        IO_UPDATE
);

  localparam logic [7:0] UPD_RELOAD = 8'(UPDATE_WIDTH - 1);

  ad9911_state_t state, state_next;
  logic          tr_q;
  logic          start;
  logic          tick;
  logic          reload;
  logic [39:0]   shreg;
  logic [5:0]    bit_cnt;
  logic [7:0]    upd_cnt;
  logic [2:0]    n_bytes;
  logic [31:0]   data_aligned;
  logic [5:0]    frame_bits;
  logic          unused_addr;

  // ADDR[7:5] are not part of the AD9911 instruction byte.
  assign unused_addr = ^ADDR[7:5];

  assign start      = TR && !tr_q && (state == ST_IDLE);
  assign n_bytes    = ad9911_reg_bytes(ADDR[4:0]);
  assign frame_bits = 6'd8 + {n_bytes, 3'b000};
  assign reload     = start || (state_next != state);

  // Push the low N data bytes up against the instruction byte; unused upper bytes fall off.
  always_comb begin
    data_aligned = DATA;
    case (n_bytes)
      3'd1:    data_aligned = {DATA[7:0], 24'd0};
      3'd2:    data_aligned = {DATA[15:0], 16'd0};
      3'd3:    data_aligned = {DATA[23:0], 8'd0};
      default: data_aligned = DATA;
    endcase
  end

  ad9911_sclk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .reload (reload),
    .tick   (tick)
  );

  // Previous TR level for rising-edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tr_q <= 1'b0;
    end else begin
      tr_q <= TR;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each serial phase lasts one tick, UPDATE lasts UPDATE_WIDTH cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_LOW;
      ST_LOW:    if (tick) state_next = ST_HIGH;
      ST_HIGH:   if (tick) state_next = (bit_cnt > 6'd1) ? ST_LOW : ST_HOLD;
      ST_HOLD:   if (tick) state_next = ST_UPDATE;
      ST_UPDATE: if (upd_cnt == 8'd0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Frame shift register and bit counter; the shift happens on HIGH->LOW so SDIO moves only on LOW entry.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg   <= 40'd0;
      bit_cnt <= 6'd0;
    end else if (start) begin
      shreg   <= {3'b000, ADDR[4:0], data_aligned};
      bit_cnt <= frame_bits;
    end else if (state == ST_HIGH && tick) begin
      shreg   <= {shreg[38:0], 1'b0};
      bit_cnt <= bit_cnt - 6'd1;
    end
  end

  // IO_UPDATE width counter, armed on the way into UPDATE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      upd_cnt <= 8'd0;
    end else if (state == ST_HOLD && tick) begin
      upd_cnt <= UPD_RELOAD;
    end else if (state == ST_UPDATE && upd_cnt != 8'd0) begin
      upd_cnt <= upd_cnt - 8'd1;
    end
  end

  // Pin levels are pure functions of the state so an async reset clears them at once.
  always_comb begin
    OVER      = (state == ST_IDLE);
    CS_N      = !(state == ST_LOW || state == ST_HIGH || state == ST_HOLD);
    SCLK      = (state == ST_HIGH);
    SDIO      = (state == ST_LOW || state == ST_HIGH) ? shreg[39] : 1'b0;
    IO_UPDATE = (state == ST_UPDATE);
  end

endmodule

// File: tb/tb_ad9911_spi_writer.sv
// tb/tb_ad9911_spi_writer.sv - self-checking bench for ad9911_spi_writer
module tb_ad9911_spi_writer;

  localparam int CLK_DIV      = 2;
  localparam int UPDATE_WIDTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        TR;
  logic [7:0]  ADDR;
  logic [31:0] DATA;
  logic        OVER;
  logic        CS_N;
  logic        SCLK;
  logic        SDIO;
  logic        IO_UPDATE;

  int tests_run = 0;
  int fails     = 0;

  ad9911_spi_writer #(
    .CLK_DIV      (CLK_DIV),
    .UPDATE_WIDTH (UPDATE_WIDTH)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .TR        (TR),
    .ADDR      (ADDR),
    .DATA      (DATA),
    .OVER      (OVER),
    .CS_N      (CS_N),
    .SCLK      (SCLK),
    .SDIO      (SDIO),
    .IO_UPDATE (IO_UPDATE)
  );

  always #5 CLK = ~CLK;

  function automatic int model_bytes(input logic [4:0] a);
    if (a == 5'h00) return 1;
    if (a == 5'h02 || a == 5'h05 || a == 5'h07) return 2;
    if (a == 5'h01 || a == 5'h03 || a == 5'h06) return 3;
    return 4;
  endfunction

  // Run one write and compare the observed pin activity with the model.
  task automatic write_and_verify(input string name, input logic [7:0] a, input logic [31:0] d,
                                  input bit hold, input int glitch_at, input int post);
    logic q_exp[$];
    logic [39:0] exp_val, got_val;
    logic [7:0] instr;
    int n, nbits_exp, nbits_got, i, over_lat, cs_low, upd_hi, pulses, extra;
    bit prev_sclk, prev_upd, done;
    n = model_bytes(a[4:0]);
    nbits_exp = 8 + 8 * n;
    instr = {3'b000, a[4:0]};
    for (int k = 7; k >= 0; k--) q_exp.push_back(instr[k]);
    for (int k = 8 * n - 1; k >= 0; k--) q_exp.push_back(d[k]);
    exp_val = 40'd0;
    foreach (q_exp[k]) exp_val = {exp_val[38:0], q_exp[k]};
    got_val = 40'd0; nbits_got = 0; over_lat = -1; cs_low = 0; upd_hi = 0; pulses = 0; extra = 0;
    done = 1'b0; i = 0;
    @(negedge CLK);
    ADDR = a; DATA = d; TR = 1'b1;
    prev_sclk = SCLK; prev_upd = IO_UPDATE;
    while (!done && i < 3000) begin
      @(negedge CLK);
      i++;
      if (i == 1) begin
        if (!hold) TR = 1'b0;
        ADDR = 8'($urandom);
        DATA = $urandom;
      end
      if (glitch_at > 0 && !hold) begin
        if (i == glitch_at) TR = 1'b1;
        if (i == glitch_at + 2) TR = 1'b0;
      end
      if (!OVER && over_lat < 0) over_lat = i;
      if (!prev_sclk && SCLK) begin
        got_val = {got_val[38:0], SDIO};
        nbits_got++;
      end
      if (!CS_N) cs_low++;
      if (IO_UPDATE) upd_hi++;
      if (IO_UPDATE && !prev_upd) pulses++;
      prev_sclk = SCLK; prev_upd = IO_UPDATE;
      if (OVER && over_lat > 0) done = 1'b1;
    end
    tests_run++;
    if (!done) begin fails++; $display("FAIL %s timeout: got no OVER return after %0d cycles, required completion", name, i); end
    tests_run++;
    if (over_lat != 1) begin fails++; $display("FAIL %s over_latency: got %0d required 1", name, over_lat); end
    tests_run++;
    if (nbits_got != nbits_exp) begin fails++; $display("FAIL %s bit_count: got %0d required %0d", name, nbits_got, nbits_exp); end
    tests_run++;
    if (got_val !== exp_val) begin fails++; $display("FAIL %s sdio_bits: got %h required %h", name, got_val, exp_val); end
    tests_run++;
    if (cs_low != 2 * CLK_DIV * nbits_exp + CLK_DIV) begin
      fails++; $display("FAIL %s cs_low_cycles: got %0d required %0d", name, cs_low, 2 * CLK_DIV * nbits_exp + CLK_DIV);
    end
    tests_run++;
    if (upd_hi != UPDATE_WIDTH || pulses != 1) begin
      fails++; $display("FAIL %s io_update: got %0d cycles/%0d pulses required %0d/1", name, upd_hi, pulses, UPDATE_WIDTH);
    end
    if (post > 0) begin
      for (int k = 0; k < post; k++) begin
        @(negedge CLK);
        if (!CS_N || IO_UPDATE || !OVER) extra++;
      end
      tests_run++;
      if (extra != 0) begin fails++; $display("FAIL %s no_retrigger: got %0d busy cycles required 0", name, extra); end
    end
    TR = 1'b0;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; TR = 1'b0; ADDR = 8'd0; DATA = 32'd0;
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({OVER, CS_N, SCLK, SDIO, IO_UPDATE} !== 5'b11000) begin
      fails++; $display("FAIL reset_outputs: got %b required 11000", {OVER, CS_N, SCLK, SDIO, IO_UPDATE});
    end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    tests_run++;
    if ({OVER, CS_N, SCLK, SDIO, IO_UPDATE} !== 5'b11000) begin
      fails++; $display("FAIL idle_outputs: got %b required 11000", {OVER, CS_N, SCLK, SDIO, IO_UPDATE});
    end
  endtask

  task automatic test_frames;
    write_and_verify("csr", 8'h00, 32'h0000_0020, 1'b0, 0, 4);
    write_and_verify("ctw0", 8'h04, 32'h0111_2222, 1'b0, 0, 4);
    write_and_verify("fr1", 8'h01, 32'h00B3_0400, 1'b0, 0, 4);
    write_and_verify("fr1_top_byte", 8'hE1, 32'hFFB3_0400, 1'b0, 0, 4);
  endtask

  task automatic test_handshake;
    write_and_verify("tr_held", 8'h05, 32'h1234_ABCD, 1'b1, 0, 12);
    write_and_verify("tr_glitch", 8'h03, 32'h00C0_FFEE, 1'b0, 10, 12);
  endtask

  task automatic test_reset_mid;
    int rises, guard, upd;
    bit prev_sclk;
    rises = 0; guard = 0; upd = 0;
    @(negedge CLK);
    ADDR = 8'h04; DATA = $urandom; TR = 1'b1;
    prev_sclk = SCLK;
    while (rises < 10 && guard < 500) begin
      @(negedge CLK);
      guard++;
      TR = 1'b0;
      if (!prev_sclk && SCLK) rises++;
      prev_sclk = SCLK;
    end
    tests_run++;
    if (rises != 10) begin fails++; $display("FAIL reset_mid_reach: got %0d rises required 10", rises); end
    #1 RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({OVER, CS_N, SCLK, SDIO, IO_UPDATE} !== 5'b11000) begin
      fails++; $display("FAIL reset_mid_outputs: got %b required 11000", {OVER, CS_N, SCLK, SDIO, IO_UPDATE});
    end
    repeat (4) begin
      @(negedge CLK);
      if (IO_UPDATE) upd++;
    end
    RESET_N = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (IO_UPDATE || !CS_N) upd++;
    end
    tests_run++;
    if (upd != 0) begin fails++; $display("FAIL reset_mid_no_update: got %0d active cycles required 0", upd); end
    write_and_verify("after_reset", 8'h04, 32'h0111_2222, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 11; r++) begin
      write_and_verify($sformatf("init_%0d", r), 8'(r), $urandom, 1'b0, 0, 0);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 12; r++) begin
      write_and_verify($sformatf("rand_%0d", r), 8'($urandom), $urandom, 1'b0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ad9911_spi_writer.md
# ad9911_spi_writer

Serial back-end for the AD9911 DDS control path. It accepts one register write at a time from the register/frequency-word sequencer over the `TR`/`ADDR`/`DATA`/`OVER` handshake. It shifts the instruction byte plus the register's natural byte count out on the AD9911 3-wire serial port, then pulses `IO_UPDATE` so the new value takes effect. It sits between the sequencer and the DDS chip pins.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `CLK` cycles; legal range 1–255.
- `UPDATE_WIDTH`, default 4: `IO_UPDATE` high time in `CLK` cycles; legal range 1–255.
- `CLK`, input, 1: system clock. The block uses one clock.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `TR`, input, 1: write request. A rising edge starts a transaction.
- `ADDR`, input, 8: register address. Only `ADDR[4:0]` is used; `ADDR[7:5]` is ignored.
- `DATA`, input, 32: register value, right-aligned. The low N bytes are sent.
- `OVER`, output, 1: high when idle or done; low while a transaction is in flight.
- `CS_N`, output, 1: chip select to the AD9911, active low.
- `SCLK`, output, 1: serial clock. Idle level is low.
- `SDIO`, output, 1: serial data (`SDIO_0`), MSB first.
- `IO_UPDATE`, output, 1: register-transfer strobe, active high.

## Operation
- Reset values:
  - `OVER` = 1, `CS_N` = 1, `SCLK` = 0, `SDIO` = 0, `IO_UPDATE` = 0.
  - State = IDLE; shift register and counters = 0.
- Request detection:
  - `TR` is registered once. A start condition is `TR` = 1 with previous `TR` = 0, sampled in IDLE.
  - On that edge, `ADDR[4:0]` and `DATA` are latched into a 40-bit shift register and `OVER` is driven 0.
  - A level held high never retriggers.
  - A `TR` rise outside IDLE is ignored. No queueing.
- Frame contents:
  - Instruction byte = {1'b0 (write), 2'b00, `ADDR[4:0]`}.
  - This is followed by N data bytes, taken as `DATA[8N-1:0]`, MSB first.
- Byte count N by address:
  - 0x00 → 1.
  - 0x02, 0x05, 0x07 → 2.
  - 0x01, 0x03, 0x06 → 3.
  - 0x04, 0x08 through 0x1F → 4.
- Bit count = 8 + 8N, i.e. 16, 24, 32 or 40.
- State machine:
  - IDLE → LOW on a start condition.
  - LOW → HIGH after `CLK_DIV` cycles.
  - HIGH → LOW after `CLK_DIV` cycles if bits remain; otherwise HIGH → HOLD.
  - HOLD → UPDATE after `CLK_DIV` cycles.
  - UPDATE → IDLE after `UPDATE_WIDTH` cycles.
- Outputs per state:
  - LOW: `CS_N` = 0, `SCLK` = 0, `SDIO` = current bit. `SDIO` changes only on entry to LOW, so it is stable across each SCLK rising edge (the edge at which the AD9911 samples).
  - HIGH: `SCLK` = 1.
  - HOLD: `SCLK` = 0, `CS_N` = 0, `SDIO` = 0.
  - UPDATE: `CS_N` = 1, `IO_UPDATE` = 1.
  - On the edge that leaves UPDATE, `IO_UPDATE` drops to 0 and `OVER` rises to 1 together.
- Reset asserted mid-frame: all outputs return to reset values immediately, without waiting for a clock edge. No `IO_UPDATE` is issued for the aborted frame.

## Timing
- `OVER` falls on the first `CLK` edge at which `TR` = 1 is seen after being 0, i.e. one cycle after the sequencer raises `TR`.
- The sequencer may check `OVER` two cycles after raising `TR`, and must see 0 by then.
- `CS_N` falls on that same edge. The first SCLK rise comes `CLK_DIV` cycles later.
- `CS_N` low duration = (2·`CLK_DIV`·bits) + `CLK_DIV` cycles.
- `IO_UPDATE` high = `UPDATE_WIDTH` cycles, beginning on the edge at which `CS_N` rises.
- Total time from the `OVER` fall to the `OVER` rise = `CS_N` low duration + `UPDATE_WIDTH`.
- `ADDR` and `DATA` may change at any time after the latch edge without affecting the frame.
- A new `TR` rise is accepted on or after the edge at which `OVER` = 1.

## Structure
- Shared package `ad9911_pkg`:
  - Register address constants (CSR, FR1, FR2, CFR, CTW0, CPOW0, ACR, LSR, RDW, FDW, CTW1).
  - Function `ad9911_reg_bytes(addr[4:0])` returning N.
  - The state enumeration.
- One sub-module, `ad9911_sclk_tick`: a down-counter that produces a one-cycle tick every `CLK_DIV` cycles. It reloads on a start condition and on every state change.
- The top level holds the FSM, the 40-bit shift register and a 6-bit bit counter.

## Test plan
- CSR write, `CLK_DIV` = 2, `ADDR` = 0x00, `DATA` = 0x00000020:
  - 16 SCLK rises; `SDIO` sampled at the rises = 0x00, 0x20.
  - `CS_N` low for 66 cycles; `IO_UPDATE` high for 4 cycles; then `OVER` = 1.
- CTW0 write, `ADDR` = 0x04, `DATA` = 0x01112222: 40 bits sampled = 0x04 01 11 22 22.
- FR1 write, `ADDR` = 0x01, `DATA` = 0x00B30400:
  - 32 bits sampled = 0x01 B3 04 00.
  - The top `DATA` byte is never sent.
- Handshake:
  - `TR` raised, then `OVER` is 0 one cycle later.
  - `TR` held high through completion: exactly one frame is sent.
  - A second `TR` pulse during SHIFT is ignored; only one `IO_UPDATE` occurs.
- Reset: `RESET_N` low during the 10th bit of a CTW0 frame:
  - `CS_N` = 1, `SCLK` = 0, `OVER` = 1 immediately; no `IO_UPDATE`.
  - The next request after release is sent correctly.
- Back-to-back: the full 11-register initialization sequence from the sequencer produces 11 frames with byte counts 1, 3, 2, 3, 4, 2, 3, 2, 4, 4, 4.
